// File: rtl/vga_line_prefetch_if.sv
// vga_line_prefetch_if: pixel-side, control and SRAM read signals of the line prefetcher.
interface vga_line_prefetch_if;
    logic        line_start;
    logic [8:0]  next_line;
    logic [9:0]  pixel_x;
    logic        pixel_req;
    logic        pixel_data;
    logic        data_en;
    logic [31:0] word_address_dest;
    logic [3:0]  byte_select;
    logic [31:0] SRAM_data_in;
    logic        SRAM_busy;
    logic        underrun;
    logic [1:0]  fetch_state;
    modport master (
        output line_start, next_line, pixel_x, pixel_req, SRAM_data_in, SRAM_busy,
        input  pixel_data, data_en, word_address_dest, byte_select, underrun, fetch_state
    );
    modport slave (
        input  line_start, next_line, pixel_x, pixel_req, SRAM_data_in, SRAM_busy,
        output pixel_data, data_en, word_address_dest, byte_select, underrun, fetch_state
    );
endinterface

// File: rtl/vga_line_prefetch.sv
// vga_line_prefetch: double-buffered 1bpp line fetcher; fills the back buffer from SRAM
// while the front buffer serves pixel reads, swapping on line_start.
module vga_line_prefetch #(
    parameter int          WORDS_PER_LINE = 20,
    parameter logic [31:0] FB_BASE        = 32'h0000_0000,
    parameter int          V_ACTIVE       = 480
) (
    input logic               clk,
    input logic               nrst,
    vga_line_prefetch_if.slave bus
);
    localparam int IW = WORDS_PER_LINE > 1 ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS_PER_LINE - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, READY = 2'd2} state_e;
    state_e          state_q;
    logic            front_sel_q;
    logic            underrun_q;
    logic            pixel_q;
    logic [1:0]      blank_q;
    logic [8:0]      line_q;
    logic [IW-1:0]   word_idx_q;
    logic [31:0]     buf_q [2][WORDS_PER_LINE];
    logic            data_en;
    logic            accept;
    logic            new_back;
    logic [IW-1:0]   rd_idx;
    logic [31:0]     rd_word;
    logic            pixel_d;
    assign data_en  = state_q == FETCH;
    assign accept   = data_en && !bus.SRAM_busy;
    // buffer that will be filled after a line_start in the current state
    assign new_back = state_q == READY ? front_sel_q : ~front_sel_q;
    assign rd_idx   = IW'(bus.pixel_x >> 5);
    assign rd_word  = buf_q[front_sel_q][rd_idx];
    assign pixel_d  = !blank_q[front_sel_q] && 32'(bus.pixel_x) < 32'(32 * WORDS_PER_LINE)
                      && rd_word[bus.pixel_x[4:0]];
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            word_idx_q  <= '0;
            blank_q     <= 2'b11;
            pixel_q     <= 1'b0;
            underrun_q  <= 1'b0;
            line_q      <= '0;
        end else begin
            if (bus.pixel_req)
                pixel_q <= pixel_d;
            if (bus.line_start) begin
                if (state_q == READY)
                    front_sel_q <= ~front_sel_q;
                if (state_q == FETCH) begin
                    underrun_q           <= 1'b1;
                    blank_q[front_sel_q] <= 1'b1;
                end
                blank_q[new_back] <= 1'b1;
                line_q            <= bus.next_line;
                word_idx_q        <= '0;
                state_q           <= 32'(bus.next_line) >= 32'(V_ACTIVE) ? READY : FETCH;
            end else if (accept) begin
                word_idx_q <= word_idx_q == LAST ? '0 : word_idx_q + 1'b1;
                if (word_idx_q == LAST) begin
                    state_q               <= READY;
                    blank_q[~front_sel_q] <= 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (nrst && accept)
            buf_q[~front_sel_q][word_idx_q] <= bus.SRAM_data_in;
    end
    assign bus.data_en           = data_en;
    assign bus.word_address_dest = data_en ? FB_BASE + 32'(line_q) * 32'(WORDS_PER_LINE) + 32'(word_idx_q) : '0;
    assign bus.byte_select       = {4{data_en}};
    assign bus.pixel_data        = pixel_q;
    assign bus.underrun          = underrun_q;
    assign bus.fetch_state       = state_q;
endmodule

// File: tb/tb_vga_line_prefetch.sv
// tb_vga_line_prefetch: directed checks of fetch timing, stalls, swaps, underrun and blank lines.
module tb_vga_line_prefetch;
    logic clk = 1'b0;
    logic nrst;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc;
    int   px [4];
    logic pe [4];
    always #5 clk = ~clk;
    vga_line_prefetch_if bus ();
    vga_line_prefetch #(
        .WORDS_PER_LINE(20),
        .FB_BASE(32'h0000_0000),
        .V_ACTIVE(480)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .bus(bus)
    );
    // memory: even words all ones, odd words zero
    assign bus.SRAM_data_in = bus.word_address_dest[0] ? 32'h0000_0000 : 32'hFFFF_FFFF;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_pix(input int x, input logic exp);
        bus.pixel_x   = 10'(x);
        bus.pixel_req = 1'b1;
        tick();
        bus.pixel_req = 1'b0;
        chk($sformatf("pixel_x=%0d", x), 32'(bus.pixel_data), 32'(exp));
    endtask
    task automatic line_start(input int line);
        bus.next_line  = 9'(line);
        bus.line_start = 1'b1;
        tick();
        bus.line_start = 1'b0;
    endtask
    task automatic do_fetch(input logic [31:0] base, input int stall_at, input int stall_len,
                            input bit pix, input int limit, output int n);
        int idx;
        idx = 0;
        n   = 0;
        while (bus.fetch_state == 2'd1 && n < limit) begin
            bus.SRAM_busy = n >= stall_at && n < stall_at + stall_len;
            bus.pixel_req = pix && n < 4;
            if (pix && n < 4)
                bus.pixel_x = 10'(px[n]);
            chk("fetch_addr", bus.word_address_dest, base + 32'(idx));
            chk("fetch_data_en", 32'(bus.data_en), 32'd1);
            chk("fetch_byte_select", 32'(bus.byte_select), 32'hF);
            if (!bus.SRAM_busy)
                idx++;
            tick();
            n++;
            if (pix && n <= 4)
                chk($sformatf("fetch_pixel_%0d", px[n-1]), 32'(bus.pixel_data), 32'(pe[n-1]));
        end
        bus.SRAM_busy = 1'b0;
        bus.pixel_req = 1'b0;
    endtask
    initial begin
        nrst           = 1'b0;
        bus.line_start = 1'b0;
        bus.next_line  = '0;
        bus.pixel_x    = '0;
        bus.pixel_req  = 1'b0;
        bus.SRAM_busy  = 1'b0;
        repeat (2) tick();
        nrst = 1'b1;
        tick();
        chk("rst_pixel_data", 32'(bus.pixel_data), 32'd0);
        chk("rst_data_en", 32'(bus.data_en), 32'd0);
        chk("rst_addr", bus.word_address_dest, 32'd0);
        chk("rst_byte_select", 32'(bus.byte_select), 32'd0);
        chk("rst_underrun", 32'(bus.underrun), 32'd0);
        chk("rst_fetch_state", 32'(bus.fetch_state), 32'd0);
        // line 0 from IDLE: 20 back-to-back accepts
        line_start(0);
        do_fetch(32'd0, 1000, 0, 1'b0, 100, cyc);
        chk("line0_cycles", 32'(cyc), 32'd20);
        chk("line0_state", 32'(bus.fetch_state), 32'd2);
        chk("line0_data_en_done", 32'(bus.data_en), 32'd0);
        chk("line0_byte_select_done", 32'(bus.byte_select), 32'd0);
        check_pix(0, 1'b0);
        // swap to line 0, fetch line 1 while reading pixels
        px = '{0, 31, 32, 63};
        pe = '{1'b1, 1'b1, 1'b0, 1'b0};
        line_start(1);
        do_fetch(32'd20, 1000, 0, 1'b1, 100, cyc);
        chk("line1_cycles", 32'(cyc), 32'd20);
        chk("line1_state", 32'(bus.fetch_state), 32'd2);
        check_pix(576, 1'b1);
        check_pix(640, 1'b0);
        check_pix(0, 1'b1);
        tick();
        chk("pixel_hold", 32'(bus.pixel_data), 32'd1);
        check_pix(1023, 1'b0);
        check_pix(639, 1'b0);
        // line 2 with a 5-cycle stall
        line_start(2);
        do_fetch(32'd40, 5, 5, 1'b0, 100, cyc);
        chk("line2_stall_cycles", 32'(cyc), 32'd25);
        chk("line2_state", 32'(bus.fetch_state), 32'd2);
        check_pix(0, 1'b1);
        check_pix(33, 1'b0);
        // line 3 interrupted after 10 cycles
        px = '{135, 160, 0, 32};
        pe = '{1'b1, 1'b0, 1'b1, 1'b0};
        line_start(3);
        do_fetch(32'd60, 1000, 0, 1'b1, 10, cyc);
        chk("line3_partial_cycles", 32'(cyc), 32'd10);
        chk("line3_partial_state", 32'(bus.fetch_state), 32'd1);
        chk("line3_partial_addr", bus.word_address_dest, 32'd70);
        chk("underrun_before", 32'(bus.underrun), 32'd0);
        line_start(4);
        chk("underrun_set", 32'(bus.underrun), 32'd1);
        chk("restart_state", 32'(bus.fetch_state), 32'd1);
        px = '{0, 128, 200, 576};
        pe = '{1'b0, 1'b0, 1'b0, 1'b0};
        do_fetch(32'd80, 1000, 0, 1'b1, 100, cyc);
        chk("line4_cycles", 32'(cyc), 32'd20);
        chk("line4_state", 32'(bus.fetch_state), 32'd2);
        chk("underrun_sticky", 32'(bus.underrun), 32'd1);
        // line beyond V_ACTIVE: no reads, straight to READY
        line_start(480);
        chk("blank_line_state", 32'(bus.fetch_state), 32'd2);
        chk("blank_line_data_en", 32'(bus.data_en), 32'd0);
        chk("blank_line_addr", bus.word_address_dest, 32'd0);
        tick();
        chk("blank_line_data_en_later", 32'(bus.data_en), 32'd0);
        check_pix(0, 1'b1);
        line_start(5);
        foreach (px[i]) px[i] = 0;
        check_pix(0, 1'b0);
        check_pix(31, 1'b0);
        check_pix(576, 1'b0);
        check_pix(639, 1'b0);
        chk("underrun_final", 32'(bus.underrun), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
